// File: rtl/exposure_readout_sequencer.sv
// Frame sequencer for the pixel array: erase, expose, two-row readout with
// ADC strobes. Holds a button-adjustable exposure time that is sampled at
// frame start. All outputs are registered.
module exposure_readout_sequencer #(
    parameter int EXP_W       = 5,
    parameter int EXP_MIN     = 2,
    parameter int EXP_MAX     = 30,
    parameter int EXP_DEFAULT = 10,
    parameter int ERASE_CYC   = 4,
    parameter int ADC_CYC     = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    output logic             Erase,
    output logic             Expose,
    output logic             NRE_1,
    output logic             NRE_2,
    output logic             ADC,
    output logic [EXP_W-1:0] Exp_time,
    output logic             Busy,
    output logic             Frame_done
);

    // A read phase is ADC_CYC strobe cycles framed by one quiet cycle each side.
    localparam int RD_CYC = ADC_CYC + 2;
    localparam int CW_ER  = $clog2(ERASE_CYC + 1);
    localparam int CW_RD  = $clog2(RD_CYC + 1);
    localparam int CW_A   = (CW_ER > CW_RD) ? CW_ER : CW_RD;
    localparam int CW     = (CW_A > EXP_W) ? CW_A : EXP_W;

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_GAP1, S_READ1, S_GAP2, S_READ2
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [EXP_W-1:0]  exp_lat;
    logic [EXP_W-1:0]  exp_time_n;
    logic              inc_q, dec_q;
    logic              inc_rise, dec_rise;
    logic              start;
    logic              erase_n, expose_n, nre1_n, nre2_n, adc_n, busy_n, done_n;

    assign inc_rise = Exp_increase & ~inc_q;
    assign dec_rise = Exp_decrease & ~dec_q;
    assign start    = (state == S_IDLE) && Init;

    // State, phase counter and registered outputs; all advance together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            Erase      <= 1'b0;
            Expose     <= 1'b0;
            NRE_1      <= 1'b1;
            NRE_2      <= 1'b1;
            ADC        <= 1'b0;
            Busy       <= 1'b0;
            Frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            Erase      <= erase_n;
            Expose     <= expose_n;
            NRE_1      <= nre1_n;
            NRE_2      <= nre2_n;
            ADC        <= adc_n;
            Busy       <= busy_n;
            Frame_done <= done_n;
        end
    end

    // Next state: each phase loads its length-1 and leaves when cnt hits 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (Init) begin
                    state_n = S_ERASE;
                    cnt_n   = CW'(ERASE_CYC - 1);
                end
            end
            S_ERASE: begin
                if (cnt == '0) begin
                    state_n = S_EXPOSE;
                    cnt_n   = CW'(exp_lat) - CW'(1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_EXPOSE: begin
                if (cnt == '0) begin
                    state_n = S_GAP1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_GAP1: begin
                state_n = S_READ1;
                cnt_n   = CW'(RD_CYC - 1);
            end
            S_READ1: begin
                if (cnt == '0) begin
                    state_n = S_GAP2;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_GAP2: begin
                state_n = S_READ2;
                cnt_n   = CW'(RD_CYC - 1);
            end
            S_READ2: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs land with the state.
    always_comb begin
        erase_n  = (state_n == S_ERASE);
        expose_n = (state_n == S_EXPOSE);
        nre1_n   = (state_n != S_READ1);
        nre2_n   = (state_n != S_READ2);
        // ADC is quiet on the first (cnt = RD_CYC-1) and last (cnt = 0) read cycle.
        adc_n    = ((state_n == S_READ1) || (state_n == S_READ2)) &&
                   (cnt_n != '0) && (cnt_n != CW'(RD_CYC - 1));
        busy_n   = (state_n != S_IDLE);
        done_n   = (state == S_READ2) && (state_n == S_IDLE);
    end

    // Exposure adjust: rising edges only count in IDLE, simultaneous edges cancel.
    always_comb begin
        exp_time_n = Exp_time;
        if (state == S_IDLE) begin
            if (inc_rise && !dec_rise && (Exp_time < EXP_W'(EXP_MAX)))
                exp_time_n = Exp_time + EXP_W'(1);
            else if (dec_rise && !inc_rise && (Exp_time > EXP_W'(EXP_MIN)))
                exp_time_n = Exp_time - EXP_W'(1);
        end
    end

    // Exposure register, frame-start latch and button edge history.
    // History resets high so a button held through reset release is not a step.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Exp_time <= EXP_W'(EXP_DEFAULT);
            exp_lat  <= EXP_W'(EXP_DEFAULT);
            inc_q    <= 1'b1;
            dec_q    <= 1'b1;
        end else begin
            Exp_time <= exp_time_n;
            inc_q    <= Exp_increase;
            dec_q    <= Exp_decrease;
            // Latch the pre-adjust value: a same-cycle edge only affects the next frame.
            if (start)
                exp_lat <= Exp_time;
        end
    end

endmodule

// File: tb/tb_exposure_readout_sequencer.sv
// Self-checking bench for exposure_readout_sequencer: a table of
// exposure-adjust vectors plus hand-written frame sequences, each expected
// output pushed into a scoreboard queue when its stimulus is driven.
module tb_exposure_readout_sequencer;

    localparam int EXP_W = 5;

    logic             Clk = 1'b0;
    logic             Reset, Init, Exp_increase, Exp_decrease;
    logic             Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_done;
    logic [EXP_W-1:0] Exp_time;

    typedef struct packed {
        logic             erase;
        logic             expose;
        logic             nre1;
        logic             nre2;
        logic             adc;
        logic             busy;
        logic             done;
        logic [EXP_W-1:0] et;
    } out_t;

    typedef struct {
        logic init;
        logic inc;
        logic dec;
        out_t exp;
    } vec_t;

    out_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    exposure_readout_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Init(Init),
        .Exp_increase(Exp_increase), .Exp_decrease(Exp_decrease),
        .Erase(Erase), .Expose(Expose), .NRE_1(NRE_1), .NRE_2(NRE_2),
        .ADC(ADC), .Exp_time(Exp_time), .Busy(Busy), .Frame_done(Frame_done)
    );

    always #5 Clk = ~Clk;

    function automatic out_t idle(int et);
        out_t o;
        o      = '0;
        o.nre1 = 1'b1;
        o.nre2 = 1'b1;
        o.et   = EXP_W'(et);
        return o;
    endfunction

    // Expected outputs k cycles after the Init sample, for exposure E.
    function automatic out_t frame_exp(int k, int e, int et);
        out_t o;
        o        = idle(et);
        o.busy   = (k >= 1) && (k <= 16 + e);
        o.erase  = (k >= 1) && (k <= 4);
        o.expose = (k >= 5) && (k <= 4 + e);
        o.nre1   = !((k >= 6 + e) && (k <= 10 + e));
        o.nre2   = !((k >= 12 + e) && (k <= 16 + e));
        o.adc    = ((k >= 7 + e) && (k <= 9 + e)) || ((k >= 13 + e) && (k <= 15 + e));
        o.done   = (k == 17 + e);
        return o;
    endfunction

    task automatic check(input string nm, input out_t e);
        out_t a;
        a = {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_done, Exp_time};
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got er=%b ex=%b n1=%b n2=%b adc=%b busy=%b done=%b et=%0d, expected er=%b ex=%b n1=%b n2=%b adc=%b busy=%b done=%b et=%0d",
                     nm, $time, a.erase, a.expose, a.nre1, a.nre2, a.adc, a.busy, a.done, a.et,
                     e.erase, e.expose, e.nre1, e.nre2, e.adc, e.busy, e.done, e.et);
        end
    endtask

    // Drive one cycle of inputs (at a negedge), expect outputs after the next posedge.
    task automatic cyc(input string nm, input logic i, input logic u, input logic d, input out_t e);
        Init         = i;
        Exp_increase = u;
        Exp_decrease = d;
        sb.push_back(e);
        @(negedge Clk);
        check(nm, sb.pop_front());
    endtask

    task automatic do_reset(input logic inc_hold);
        Reset        = 1'b1;
        Init         = 1'b0;
        Exp_increase = inc_hold;
        Exp_decrease = 1'b0;
        @(negedge Clk);
        check("reset_state", idle(10));
        Reset = 1'b0;
    endtask

    // One Init pulse, optional inc pulse at cycle inc_k and extra Init at init_k.
    task automatic run_frame(input string nm, input int e, input int et, input int inc_k, input int init_k);
        for (int k = 0; k <= 16 + e; k++)
            cyc(nm, (k == 0) || (k == init_k), (k == inc_k), 1'b0, frame_exp(k + 1, e, et));
        cyc({nm, "_after"}, 1'b0, 1'b0, 1'b0, idle(et));
    endtask

    initial begin
        vec_t tbl[12];
        Reset = 1'b1; Init = 1'b0; Exp_increase = 1'b0; Exp_decrease = 1'b0;
        @(negedge Clk);
        do_reset(1'b0);

        // Exposure adjust vectors: edges, holds, simultaneous edges.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, idle(10)};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, idle(11)};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, idle(11)};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, idle(11)};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, idle(10)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, idle(10)};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, idle(10)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, idle(10)};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, idle(9)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, idle(9)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, idle(10)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, idle(10)};
        for (int i = 0; i < 12; i++)
            cyc($sformatf("adj_vec%0d", i), tbl[i].init, tbl[i].inc, tbl[i].dec, tbl[i].exp);

        // Default frame.
        run_frame("frame_default", 10, 10, -1, -1);

        // Saturation at both ends, then a minimum-exposure frame.
        for (int i = 0; i < 25; i++) begin
            cyc("inc_sat", 1'b0, 1'b1, 1'b0, idle((11 + i > 30) ? 30 : 11 + i));
            cyc("inc_sat_lo", 1'b0, 1'b0, 1'b0, idle((11 + i > 30) ? 30 : 11 + i));
        end
        for (int i = 0; i < 40; i++) begin
            cyc("dec_sat", 1'b0, 1'b0, 1'b1, idle((29 - i < 2) ? 2 : 29 - i));
            cyc("dec_sat_lo", 1'b0, 1'b0, 1'b0, idle((29 - i < 2) ? 2 : 29 - i));
        end
        run_frame("frame_min", 2, 2, -1, -1);

        // Held-high increase across reset release produces no step.
        do_reset(1'b1);
        cyc("held_inc", 1'b0, 1'b1, 1'b0, idle(10));
        cyc("held_inc_rel", 1'b0, 1'b0, 1'b0, idle(10));

        // Increase edge during EXPOSE is discarded; Init while busy is ignored.
        run_frame("inc_in_expose", 10, 10, 6, 8);

        // Init held high: back-to-back frames one IDLE cycle apart.
        for (int k = 0; k <= 80; k++) begin
            int j;
            j = (k + 1) % 27;
            cyc("b2b", (k < 60), 1'b0, 1'b0, (j == 0) ? frame_exp(27, 10, 10) : frame_exp(j, 10, 10));
        end
        cyc("b2b_after", 1'b0, 1'b0, 1'b0, idle(10));

        // Init and increase in the same cycle: this frame 10, next frame 11.
        run_frame("init_inc_same", 10, 11, 0, -1);
        run_frame("next_frame_11", 11, 11, -1, -1);

        // Asynchronous reset mid-READ1 of an 11-cycle frame.
        for (int k = 0; k <= 18; k++)
            cyc("pre_async_rst", (k == 0), 1'b0, 1'b0, frame_exp(k + 1, 11, 11));
        #2 Reset = 1'b1;
        #1 check("async_rst", idle(10));
        @(negedge Clk);
        Reset = 1'b0;
        cyc("post_rst_idle", 1'b0, 1'b0, 1'b0, idle(10));
        run_frame("frame_after_rst", 10, 10, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
